// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared types, constants and decode helper for the md_sched multiply/divide controller
//
// Purpose : opcode enum, counter width, divide-by-zero fill value and the
//           long-latency op classifier used by md_sched and its bench.
// Config  : MD_MADD_EN - when defined, MADD/MADDU/MSUB are long-latency ops;
//           otherwise opcodes 7-9 decode as NOP.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9
    } md_op_t;

    localparam int MD_CNT_W = 4;

    // LO value written when the divisor is zero; HI receives the dividend.
    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

    // True for ops that occupy the unit for MUL_LAT/DIV_LAT cycles.
    function automatic logic is_long_op(input md_op_t op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB:         return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_sched.sv
// rtl/md_sched.sv - E-stage multiply/divide controller holding HI/LO and a latency counter
//
// Purpose : accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO (and MADD/MADDU/MSUB when
//           MD_MADD_EN is defined), computes the 64-bit result combinationally
//           at accept, holds it pending for MUL_LAT/DIV_LAT cycles, then commits
//           it to HI/LO.
// Config  : MD_MADD_EN - enables the multiply-accumulate opcodes 7-9.
// Ports   :
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   req       in   exception/interrupt flush; drops the op presented this cycle
//   op_valid  in   E-stage instruction is an md op
//   op        in   md_op_t opcode
//   rs_i      in   forwarded rs value
//   rt_i      in   forwarded rt value
//   hl_sel_i  in   1: hl_o = HI, 0: hl_o = LO
//   start_o   out  long op accepted this cycle (combinational)
//   busy_o    out  long op in flight (registered)
//   hi_o      out  architectural HI
//   lo_o      out  architectural LO
//   hl_o      out  HI/LO select for MFHI/MFLO
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_valid,
    input  md_op_t      op,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        hl_sel_i,
    output logic        start_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] hl_o
);

    localparam logic [MD_CNT_W-1:0] MUL_CNT = MD_CNT_W'(MUL_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_CNT = MD_CNT_W'(DIV_LAT);

    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         pend_hi_q, pend_hi_d;
    logic [31:0]         pend_lo_q, pend_lo_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic        accept;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] num, den, den_safe;
    logic [31:0] uq, ur;
    logic [31:0] q_s, r_s;
    logic [63:0] result;

    assign accept  = op_valid & ~busy_q & ~req & reset;
    assign start_o = accept & is_long_op(op);
    assign busy_o  = busy_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign hl_o    = hl_sel_i ? hi_q : lo_q;

    // Datapath: one magnitude divider serves DIV and DIVU; the signed case
    // divides absolute values and restores signs afterwards, which also gives
    // 0x8000_0000 / -1 = 0x8000_0000 rem 0 without a special case.
    always_comb begin
        prod_s     = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
        prod_u     = {32'd0, rs_i} * {32'd0, rt_i};
        div_signed = (op == MD_DIV);
        num        = (div_signed && rs_i[31]) ? -rs_i : rs_i;
        den        = (div_signed && rt_i[31]) ? -rt_i : rt_i;
        // Keeps the divider defined on a zero divisor; the result is overridden.
        den_safe   = (den == 32'd0) ? 32'd1 : den;
        uq         = num / den_safe;
        ur         = num % den_safe;
        q_s        = (rs_i[31] ^ rt_i[31]) ? -uq : uq;
        r_s        = rs_i[31] ? -ur : ur;

        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = (rt_i == 32'd0) ? {rs_i, MD_DIV0_LO} : {r_s, q_s};
            MD_DIVU:  result = (rt_i == 32'd0) ? {rs_i, MD_DIV0_LO} : {ur, uq};
`ifdef MD_MADD_EN
            MD_MADD:  result = {hi_q, lo_q} + prod_s;
            MD_MADDU: result = {hi_q, lo_q} + prod_u;
            MD_MSUB:  result = {hi_q, lo_q} - prod_s;
`endif
            default:  result = 64'd0;
        endcase
    end

    // Next state: a busy unit only counts down and commits; new ops are
    // considered only when idle (accept already excludes busy).
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;

        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == MD_CNT_W'(1)) begin
                busy_d = 1'b0;
                hi_d   = pend_hi_q;
                lo_d   = pend_lo_q;
            end
        end else if (accept) begin
            if (op == MD_MTHI) begin
                hi_d = rs_i;
            end else if (op == MD_MTLO) begin
                lo_d = rs_i;
            end else if (is_long_op(op)) begin
                pend_hi_d = result[63:32];
                pend_lo_d = result[31:0];
                cnt_d     = (op == MD_DIV || op == MD_DIVU) ? DIV_CNT : MUL_CNT;
                busy_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - scoreboard bench for md_sched (honours MD_MADD_EN when defined)
module tb_md_sched;
    import md_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        op_valid = 1'b0;
    md_op_t      op = MD_NOP;
    logic [31:0] rs_i = 32'd0;
    logic [31:0] rt_i = 32'd0;
    logic        hl_sel_i = 1'b0;
    logic        start_o, busy_o;
    logic [31:0] hi_o, lo_o, hl_o;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .op_valid(op_valid), .op(op),
        .rs_i(rs_i), .rt_i(rt_i), .hl_sel_i(hl_sel_i),
        .start_o(start_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o), .hl_o(hl_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            MD_MULT:  return 64'(sp);
            MD_MULTU: return up;
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MD_MADD:  return {hi, lo} + 64'(sp);
            MD_MADDU: return {hi, lo} + up;
            MD_MSUB:  return {hi, lo} - 64'(sp);
            default:  return {hi, lo};
        endcase
    endfunction

    // Presents one op for a cycle; checks start_o and pushes the expected result.
    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_start, input bit now, input bit rq);
        if (!now) @(negedge clk);
        op_valid = 1'b1; op = o; rs_i = a; rt_i = b; req = rq;
        #1;
        total_cnt++;
        if (start_o !== exp_start) $display("FAIL start_o op=%0d: got %0b want %0b", o, start_o, exp_start);
        else pass_cnt++;
        if (exp_start) exp_q.push_back(model(o, a, b, m_hi, m_lo));
        @(posedge clk);
        #1;
        op_valid = 1'b0; req = 1'b0; op = MD_NOP;
    endtask

    // Counts busy cycles, optionally pulses req or an MTHI during busy, then
    // compares the committed HI/LO against the scoreboard head.
    task automatic wait_done(input int lat, input int req_cyc, input int mthi_cyc);
        int          k;
        bit          done;
        logic [63:0] e;
        k = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            req = 1'b0; op_valid = 1'b0; op = MD_NOP;
            if (busy_o === 1'b1) begin
                k++;
                total_cnt++;
                if (hi_o !== m_hi || lo_o !== m_lo)
                    $display("FAIL hold_hilo cyc=%0d: got %h_%h want %h_%h", k, hi_o, lo_o, m_hi, m_lo);
                else pass_cnt++;
                if (k == req_cyc) req = 1'b1;
                if (k == mthi_cyc) begin
                    op_valid = 1'b1; op = MD_MTHI; rs_i = 32'hDEAD_BEEF;
                    #1;
                    total_cnt++;
                    if (start_o !== 1'b0) $display("FAIL mthi_busy_start: got %0b want 0", start_o);
                    else pass_cnt++;
                end
            end else begin
                done = 1'b1;
            end
        end
        req = 1'b0; op_valid = 1'b0; op = MD_NOP;
        total_cnt++;
        if (k != lat || !done) $display("FAIL busy_len: got %0d want %0d", k, lat);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = exp_q.pop_front();
            if ({hi_o, lo_o} !== e) $display("FAIL commit: got %h_%h want %h_%h", hi_o, lo_o, e[63:32], e[31:0]);
            else pass_cnt++;
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b1; op = MD_MULT; rs_i = 32'd3; rt_i = 32'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (start_o !== 1'b0) $display("FAIL reset_start: got %0b want 0", start_o); else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else pass_cnt++;
        total_cnt++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || hl_o !== 32'd0)
            $display("FAIL reset_hilo: got %h_%h hl %h want 0_0 hl 0", hi_o, lo_o, hl_o);
        else pass_cnt++;
        op_valid = 1'b0; op = MD_NOP;
        reset = 1'b1;
    endtask

    task automatic test_mult();
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 0, 0);
        total_cnt++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA)
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", hi_o, lo_o);
        else pass_cnt++;
    endtask

    task automatic test_divu();
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
        wait_done(DIV_LAT, 0, 0);
        hl_sel_i = 1'b0; #1;
        total_cnt++;
        if (hl_o !== 32'd14) $display("FAIL mflo: got %0d want 14", hl_o); else pass_cnt++;
        hl_sel_i = 1'b1; #1;
        total_cnt++;
        if (hl_o !== 32'd2) $display("FAIL mfhi: got %0d want 2", hl_o); else pass_cnt++;
        hl_sel_i = 1'b0;
    endtask

    task automatic test_div_cases();
        issue(MD_DIV, -32'sd7, 32'd2, 1'b1, 1'b0, 1'b0);
        wait_done(DIV_LAT, 0, 0);
        total_cnt++;
        if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF)
            $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", hi_o, lo_o);
        else pass_cnt++;
        issue(MD_DIV, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
        wait_done(DIV_LAT, 0, 0);
        total_cnt++;
        if (hi_o !== 32'd5 || lo_o !== 32'hFFFF_FFFF)
            $display("FAIL div_zero: got %h_%h want 00000005_ffffffff", hi_o, lo_o);
        else pass_cnt++;
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        wait_done(DIV_LAT, 0, 0);
        total_cnt++;
        if (hi_o !== 32'd0 || lo_o !== 32'h8000_0000)
            $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi_o, lo_o);
        else pass_cnt++;
    endtask

    task automatic test_random();
        md_op_t ops[4];
        md_op_t o;
        ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV; ops[3] = MD_DIVU;
        for (int i = 0; i < 8; i++) begin
            o = ops[i % 4];
            issue(o, $urandom, (i == 6) ? 32'd0 : $urandom_range(32'hFFFF_FFFF, 0), 1'b1, 1'b0, 1'b0);
            wait_done((o == MD_DIV || o == MD_DIVU) ? DIV_LAT : MUL_LAT, 0, 0);
        end
    endtask

    task automatic test_mtlo();
        issue(MD_MTLO, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0);
        m_lo = 32'h0000_1234;
        total_cnt++;
        if (lo_o !== 32'h0000_1234 || hi_o !== m_hi || busy_o !== 1'b0)
            $display("FAIL mtlo: got lo %h hi %h busy %0b want lo 00001234 hi %h busy 0", lo_o, hi_o, busy_o, m_hi);
        else pass_cnt++;
    endtask

    task automatic test_req();
        issue(MD_MULT, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo)
            $display("FAIL req_drop: got busy %0b %h_%h want busy 0 %h_%h", busy_o, hi_o, lo_o, m_hi, m_lo);
        else pass_cnt++;
        issue(MD_MULT, 32'd1000, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 2, 0);
    endtask

    task automatic test_mthi_busy();
        issue(MD_MULT, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 0, 2);
        total_cnt++;
        if (hi_o !== 32'd0) $display("FAIL mthi_ignored: got %h want 0", hi_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 0, 0);
        issue(MD_DIVU, 32'd1_000_000, 32'd999, 1'b1, 1'b1, 1'b0);
        wait_done(DIV_LAT, 0, 0);
    endtask

    task automatic test_reset_mid();
        issue(MD_DIV, 32'd100, 32'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        total_cnt++;
        if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0)
            $display("FAIL reset_mid: got busy %0b %h_%h want busy 0 0_0", busy_o, hi_o, lo_o);
        else pass_cnt++;
        repeat (12) @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0)
            $display("FAIL reset_no_commit: got busy %0b %h_%h want busy 0 0_0", busy_o, hi_o, lo_o);
        else pass_cnt++;
    endtask

    task automatic test_madd();
        issue(MD_MTHI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        m_hi = 32'd0;
        issue(MD_MTLO, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        m_lo = 32'd1;
`ifdef MD_MADD_EN
        issue(MD_MADD, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 0, 0);
        total_cnt++;
        if (hi_o !== 32'd0 || lo_o !== 32'd7) $display("FAIL madd: got %h_%h want 0_7", hi_o, lo_o);
        else pass_cnt++;
        issue(MD_MSUB, 32'd4, 32'd5, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 0, 0);
        issue(MD_MADDU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
        wait_done(MUL_LAT, 0, 0);
`else
        issue(MD_MADD, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        issue(MD_MSUB, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd1)
            $display("FAIL madd_off: got busy %0b %h_%h want busy 0 0_1", busy_o, hi_o, lo_o);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_div_cases();
        test_random();
        test_mtlo();
        test_req();
        test_mthi_busy();
        test_back_to_back();
        test_reset_mid();
        test_madd();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
